// File: rtl/mult_sched_pkg.sv
// Shared types, limits and fixed-point helpers for the time-multiplexed voice multiplier.
// Samples are signed Q1.15.
package mult_sched_pkg;

    localparam int BITS   = 16;
    localparam int AW_MAX = BITS + 5;

    typedef logic signed [BITS-1:0]   sample_t;
    typedef logic signed [AW_MAX-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam sample_t SMAX = sample_t'({1'b0, {(BITS-1){1'b1}}});
    localparam sample_t SMIN = sample_t'({1'b1, {(BITS-1){1'b0}}});

    function automatic sample_t sat_clamp(input wide_t a);
        sample_t r;
        if (a > wide_t'(SMAX)) begin
            r = SMAX;
        end else if (a < wide_t'(SMIN)) begin
            r = SMIN;
        end else begin
            r = a[BITS-1:0];
        end
        return r;
    endfunction

    // Q1.15 product, floored; -1 x -1 is the only result that cannot be represented.
    function automatic sample_t q_mul(input sample_t a, input sample_t b);
        logic signed [2*BITS-1:0] full;
        logic signed [2*BITS-1:0] sh;
        sample_t r;
        full = (2*BITS)'(a) * (2*BITS)'(b);
        sh   = full >>> (BITS-1);
        if ((a == SMIN) && (b == SMIN)) begin
            r = SMAX;
        end else begin
            r = sh[BITS-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Voice operand / product bus between the voice blocks and the shared-multiplier scheduler.
interface mult_sched_if #(parameter int N = 4);
    import mult_sched_pkg::*;

    logic              sampleTick;
    logic [N*BITS-1:0] xIn;
    logic [N*BITS-1:0] yIn;
    logic [N-1:0]      enaMask;
    logic [N*BITS-1:0] sigOut;
    logic [BITS-1:0]   mixOut;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output sampleTick, xIn, yIn, enaMask,
        input  sigOut, mixOut, busy, done, overrun
    );

    modport slave (
        input  sampleTick, xIn, yIn, enaMask,
        output sigOut, mixOut, busy, done, overrun
    );

endinterface

// File: rtl/dsp_mult.sv
// Signed Q1.15 multiplier shared by all voices.
module dsp_mult
    import mult_sched_pkg::*;
(
    input  sample_t a,
    input  sample_t b,
    output sample_t p
);

    assign p = q_mul(a, b);

endmodule

// File: rtl/mult_sched_sat_accum.sv
// Clearable wide accumulator of voice products with a saturating Q1.15 view of the sum.
module mult_sched_sat_accum
    import mult_sched_pkg::*;
#(
    parameter int AW = BITS + 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    en,
    input  sample_t din,
    output sample_t sat
);

    logic signed [AW-1:0] acc_r;

    // Running sum, wide enough that N full-scale products never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {AW{1'b0}};
        end else if (clr) begin
            acc_r <= {AW{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + AW'(din);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign sat = sat_clamp(AW_MAX'(acc_r));

endmodule

// File: rtl/mult_sched.sv
// Scheduler that walks N snapshotted voice operand pairs through one dsp_mult per sample
// and publishes all products plus a saturated mix in a single cycle.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    mult_sched_if.slave bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = BITS + $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t            state_r;
    state_t            state_s;
    logic [IW-1:0]     idx_r;
    sample_t           snap_x_r [N];
    sample_t           snap_y_r [N];
    logic [N-1:0]      ena_r;
    sample_t           work_r [N];
    logic [N*BITS-1:0] sig_r;
    logic [N*BITS-1:0] sig_pack_s;
    sample_t           mix_r;
    logic              done_r;
    logic              pending_r;
    logic              pending_s;
    logic              overrun_r;
    logic              overrun_s;
    logic              capture_s;
    logic              step_s;
    logic              publish_s;
    sample_t           mul_p_s;
    sample_t           prod_s;
    sample_t           sat_s;

    dsp_mult u_mult (
        .a (snap_x_r[idx_r]),
        .b (snap_y_r[idx_r]),
        .p (mul_p_s)
    );

    assign prod_s = ena_r[idx_r] ? mul_p_s : sample_t'({BITS{1'b0}});

    mult_sched_sat_accum #(.AW(AW)) u_accum (
        .clk (clk),
        .rst (rst),
        .clr (capture_s),
        .en  (step_s),
        .din (prod_s),
        .sat (sat_s)
    );

    // Next state, datapath strobes and the pending/overrun bookkeeping for ticks seen while busy.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        step_s    = 1'b0;
        publish_s = 1'b0;
        pending_s = pending_r;
        overrun_s = overrun_r;
        case (state_r)
            IDLE: begin
                if (bus.sampleTick) begin
                    capture_s = 1'b1;
                    state_s   = SCAN;
                end else begin
                    state_s   = IDLE;
                end
            end
            SCAN: begin
                step_s = 1'b1;
                if (bus.sampleTick && pending_r) begin
                    overrun_s = 1'b1;
                end else if (bus.sampleTick) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (idx_r == LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                // A tick landing on DONE restarts directly; with one already pending it is the lost one.
                publish_s = 1'b1;
                pending_s = 1'b0;
                if (bus.sampleTick && pending_r) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                if (pending_r || bus.sampleTick) begin
                    capture_s = 1'b1;
                    state_s   = SCAN;
                end else begin
                    state_s   = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, round index and tick bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= {IW{1'b0}};
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            overrun_r <= overrun_s;
            if (capture_s) begin
                idx_r <= {IW{1'b0}};
            end else if (step_s) begin
                idx_r <= (idx_r == LAST) ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Operand snapshot and per-voice working products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_r <= {N{1'b0}};
            for (int k = 0; k < N; k++) begin
                snap_x_r[k] <= sample_t'({BITS{1'b0}});
                snap_y_r[k] <= sample_t'({BITS{1'b0}});
                work_r[k]   <= sample_t'({BITS{1'b0}});
            end
        end else begin
            if (capture_s) begin
                ena_r <= bus.enaMask;
                for (int k = 0; k < N; k++) begin
                    snap_x_r[k] <= bus.xIn[k*BITS +: BITS];
                    snap_y_r[k] <= bus.yIn[k*BITS +: BITS];
                end
            end else begin
                ena_r <= ena_r;
            end
            if (step_s) begin
                work_r[idx_r] <= prod_s;
            end else begin
                work_r[idx_r] <= work_r[idx_r];
            end
        end
    end

    // Flatten the working registers into the packed output layout.
    always_comb begin
        sig_pack_s = {(N*BITS){1'b0}};
        for (int k = 0; k < N; k++) begin
            sig_pack_s[k*BITS +: BITS] = work_r[k];
        end
    end

    // Published outputs; all voices and the mix change together on the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_r  <= {(N*BITS){1'b0}};
            mix_r  <= sample_t'({BITS{1'b0}});
            done_r <= 1'b0;
        end else if (publish_s) begin
            sig_r  <= sig_pack_s;
            mix_r  <= sat_s;
            done_r <= 1'b1;
        end else begin
            sig_r  <= sig_r;
            mix_r  <= mix_r;
            done_r <= 1'b0;
        end
    end

    assign bus.sigOut  = sig_r;
    assign bus.mixOut  = mix_r;
    assign bus.done    = done_r;
    assign bus.busy    = (state_r != IDLE);
    assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_mult_sched.sv
// Table-driven and sequence checks of mult_sched with a done-driven scoreboard (N=4, BITS=16).
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int NV = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_sched_if #(.N(NV)) bus ();

    mult_sched #(.N(NV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NV*W-1:0] sig;
        logic [W-1:0]    mix;
        int              done_cyc;
    } exp_t;

    typedef struct {
        logic [NV*W-1:0] xs;
        logic [NV*W-1:0] ys;
        logic [NV-1:0]   ena;
        logic [NV*W-1:0] sig;
        logic [W-1:0]    mix;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   c     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NV*W-1:0] p4(input int a, input int b, input int d2, input int d3);
        return {W'(d3), W'(d2), W'(b), W'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, got, want);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding round.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 want done=0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                for (int v = 0; v < NV; v++) begin
                    chk($sformatf("sig%0d", v), 32'(bus.sigOut[v*W +: W]), 32'(e.sig[v*W +: W]));
                end
                chk("mix", 32'(bus.mixOut), 32'(e.mix));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input vec_t v);
        bus.xIn     = v.xs;
        bus.yIn     = v.ys;
        bus.enaMask = v.ena;
    endtask

    task automatic push(input vec_t v, input int dc);
        exp_t e;
        e.sig      = v.sig;
        e.mix      = v.mix;
        e.done_cyc = dc;
        sb.push_back(e);
    endtask

    task automatic tick();
        bus.sampleTick = 1'b1;
        step(1);
        bus.sampleTick = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            step(1);
            k++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d rounds outstanding want 0", name, sb.size());
            sb.delete();
        end
        step(2);
    endtask

    initial begin
        bus.sampleTick = 1'b0;
        bus.xIn        = '0;
        bus.yIn        = '0;
        bus.enaMask    = '0;

        vecs[0] = '{xs: p4(16384, 16384, 16384, 16384), ys: p4(16384, 16384, 16384, 16384),
                    ena: 4'hF, sig: p4(8192, 8192, 8192, 8192), mix: W'(32767)};
        vecs[1] = '{xs: p4(-32768, 0, 0, 0), ys: p4(-32768, 0, 0, 0),
                    ena: 4'hF, sig: p4(32767, 0, 0, 0), mix: W'(32767)};
        vecs[2] = '{xs: p4(16384, 16384, 0, 0), ys: p4(-16384, -16384, 0, 0),
                    ena: 4'b0001, sig: p4(-8192, 0, 0, 0), mix: W'(-8192)};
        vecs[3] = '{xs: p4(-32768, -32768, -32768, -32768), ys: p4(32767, 32767, 32767, 32767),
                    ena: 4'hF, sig: p4(-32767, -32767, -32767, -32767), mix: W'(-32768)};
        vecs[4] = '{xs: p4(1, 1, 3, -3), ys: p4(-1, 1, 16384, 16384),
                    ena: 4'hF, sig: p4(-1, 0, 1, -2), mix: W'(-2)};
        vecs[5] = '{xs: p4(100, -200, 300, -400), ys: p4(20000, 20000, -20000, 20000),
                    ena: 4'h0, sig: p4(0, 0, 0, 0), mix: W'(0)};

        step(3);
        chk("rst_sig_lo", bus.sigOut[31:0], 32'd0);
        chk("rst_sig_hi", bus.sigOut[63:32], 32'd0);
        chk("rst_mix", 32'(bus.mixOut), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b0;
        step(2);

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            c = cyc;
            push(vecs[i], c + NV + 2);
            tick();
            chk("busy_in_scan", 32'(bus.busy), 32'd1);
            drain($sformatf("vec%0d", i));
            chk("busy_idle", 32'(bus.busy), 32'd0);
        end

        // Second tick two cycles in, operands changed mid-scan: round 2 uses the restart-time values.
        drive(vecs[0]);
        c = cyc;
        push(vecs[0], c + 6);
        tick();
        step(1);
        push(vecs[2], c + 11);
        tick();
        drive(vecs[2]);
        drain("back_to_back");
        chk("b2b_overrun", 32'(bus.overrun), 32'd0);

        // Third tick while one is already pending is lost and latches overrun.
        drive(vecs[1]);
        c = cyc;
        push(vecs[1], c + 6);
        tick();
        step(1);
        tick();
        drive(vecs[3]);
        tick();
        push(vecs[3], c + 11);
        drain("overrun_rounds");
        step(8);
        chk("overrun_set", 32'(bus.overrun), 32'd1);
        drive(vecs[4]);
        c = cyc;
        push(vecs[4], c + 6);
        tick();
        drain("after_overrun");
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Reset in the second scan cycle aborts the round with no done pulse.
        drive(vecs[0]);
        tick();
        step(1);
        rst = 1'b1;
        #1;
        chk("midrst_sig_lo", bus.sigOut[31:0], 32'd0);
        chk("midrst_sig_hi", bus.sigOut[63:32], 32'd0);
        chk("midrst_mix", 32'(bus.mixOut), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_overrun", 32'(bus.overrun), 32'd0);
        step(2);
        rst = 1'b0;
        step(10);
        drive(vecs[0]);
        c = cyc;
        push(vecs[0], c + 6);
        tick();
        drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
Time-multiplexed scheduler that shares a single dsp_mult instance among N voices. Each voice supplies an envelope × oscillator product request.
- On every sample strobe, it snapshots all N operand pairs and walks them through the shared multiplier, one per clk cycle.
- It then publishes the per-voice products plus a saturated mix, with all outputs updating atomically.
- It sits between the per-voice osc/envseq blocks and the sketch output `sig`. It replaces N parallel dsp_mult instances.

Parameters:
N, 4, number of voices sharing the multiplier (2..16).
BITS, `BITS (16), sample width; samples are signed Q1.(BITS-1).

Ports:
clk  in  1  DSP clock (dspclk in sketches).
rst  in  1  asynchronous, active-high reset.
sampleTick  in  1  one-cycle strobe at sample rate; starts a scheduling round.
xIn  in  N*BITS  packed operand A per voice (voice k at bits [k*BITS +: BITS]), typically envelope.
yIn  in  N*BITS  packed operand B per voice, typically oscillator.
enaMask  in  N  per-voice enable; disabled voice yields product 0.
sigOut  out  N*BITS  packed per-voice products, registered.
mixOut  out  BITS  saturated sum of all products, registered.
busy  out  1  high in SCAN and DONE states.
done  out  1  one-cycle pulse when sigOut/mixOut update.
overrun  out  1  sticky; a tick was lost.

Behaviour:
- Reset (async, any state): state=IDLE; idx=0; acc=0; pending=0; all working regs=0; sigOut=0; mixOut=0; done=0; overrun=0.
- States are IDLE, SCAN, DONE.
- IDLE, sampleTick=1: capture xIn, yIn, enaMask into snapshot regs; idx=0; acc=0; go SCAN.
- SCAN:
  - Each cycle, present snapshot pair idx to the shared multiplier.
  - prod = (x*y) >>> (BITS-1), computed on a 2*BITS-bit full product, arithmetic shift (truncation toward -inf).
  - The case x=y=MIN (-1 × -1) saturates to MAX.
  - If enaMask[idx]=0, prod=0.
  - Write prod to working reg[idx]; acc += sign-extended prod. acc is BITS+clog2(N) bits wide, so there is no internal overflow.
  - When idx=N-1, go DONE; otherwise idx++.
- DONE (1 cycle):
  - sigOut <= working regs (all voices at once; double-buffered, so no partial update is ever visible).
  - mixOut <= clamp(acc, MIN, MAX).
  - done=1 in the cycle after the DONE state, coincident with the new outputs.
  - If pending=1: clear pending, recapture operands, go SCAN. Otherwise go IDLE.
- Latency: tick sampled at edge t → outputs valid and done=1 after edge t+N+1. Throughput is one round per N+1 cycles.
- Tick while busy:
  - If pending=0, set pending. The operands are NOT captured now; they are captured at the restart.
  - If pending=1 already, set overrun (sticky until rst).
- Tick in the same cycle DONE is active counts as a busy tick and sets pending. Restart then happens with no idle gap.
- Operands changing during SCAN have no effect on the current round.
- Reset mid-round: outputs return to 0 immediately. No done pulse is emitted for the aborted round.
- MAX = 2^(BITS-1)-1; MIN = -2^(BITS-1).

Decomposition:
- Shared package mult_sched_pkg holds:
  - sample_t (signed [BITS-1:0]);
  - state enum {IDLE, SCAN, DONE};
  - SMAX/SMIN constants;
  - function sat_clamp(wide acc) → sample_t;
  - function q_mul(sample_t, sample_t) implementing the rounding and MIN×MIN rule above.
- One existing dsp_mult instance is used as the shared multiplier.
- One natural sub-module: sat_accum (clearable accumulator plus output clamp).

Test Plan:
- N=4, BITS=16, all enabled, x=16384, y=16384 each voice, one tick:
  - done exactly 5 cycles after the tick;
  - each sigOut voice=8192;
  - mixOut=32767 (sum 32768 clamped).
- x=-32768, y=-32768 on voice 0, others 0:
  - sigOut[0]=32767;
  - mixOut=32767.
- x=16384, y=-16384 on voices 0 and 1, enaMask=4'b0001:
  - sigOut[0]=-8192, sigOut[1]=0;
  - mixOut=-8192.
- Back-to-back ticks:
  - tick, then a second tick 2 cycles later → second round starts right after DONE; done pulses at t+5 and t+10; overrun=0.
  - A third tick during the second round's wait → overrun=1 and it stays 1.
- Change xIn during SCAN → outputs reflect the operands captured at the tick.
- Assert rst at cycle 2 of SCAN → sigOut=0, mixOut=0, busy=0 immediately; no done pulse; the next tick completes normally.
